// File: rtl/bit_echo_printer_pkg.sv
// Shared types and ASCII constants for the bit echo printer.
package bit_echo_printer_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    PRINT,
    CR,
    LF
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ONE  = 8'h31;
  localparam logic [7:0] ASCII_BS   = 8'h08;
  localparam logic [7:0] ASCII_DEL  = 8'h7F;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

endpackage

// File: rtl/bit_echo_printer_tx_byte_sequencer.sv
// Issues one byte per request to a UART transmitter, keeping a one-cycle
// gap after every strobe so a late-rising tx_busy is never missed.
module tx_byte_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [7:0] tx_byte,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  output logic       done
);

  // A strobe in the previous cycle is exactly new_tx_data being high now.
  assign done = req && !tx_busy && !new_tx_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the reset branch is asynchronous, active-low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data     <= '0;
      new_tx_data <= 1'b0;
    end else begin
      new_tx_data <= done;
      if (done) tx_data <= tx_byte;
    end
  end

endmodule

// File: rtl/bit_echo_printer.sv
// Collects DIGITS ASCII binary digits with backspace editing, publishes the
// packed value, then echoes the digits (optionally reversed, optional CR/LF).
module bit_echo_printer
  import bit_echo_printer_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter bit REVERSE     = 1'b1,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              new_rx_data,
  output logic [7:0]        tx_data,
  output logic              new_tx_data,
  input  logic              tx_busy,
  output logic [DIGITS-1:0] value,
  output logic              value_valid,
  output logic              busy
);

  localparam int              CW   = $clog2(DIGITS + 1);
  localparam logic [CW-1:0]   LAST = CW'(DIGITS - 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     count, idx, sel;
  logic [DIGITS-1:0] shreg, shreg_next;
  logic              is_digit, is_erase, accept_digit, accept_erase, complete;
  logic              req, done, digit;
  logic [7:0]        tx_byte;

  assign is_digit     = (rx_data == ASCII_ZERO) || (rx_data == ASCII_ONE);
  assign is_erase     = ((rx_data == ASCII_BS) || (rx_data == ASCII_DEL)) && (count != '0);
  assign accept_digit = (state == COLLECT) && new_rx_data && is_digit;
  assign accept_erase = (state == COLLECT) && new_rx_data && is_erase;
  assign complete     = accept_digit && (count == LAST);
  assign shreg_next   = DIGITS'({shreg, rx_data[0]});
  assign busy         = (state != COLLECT);

  // Reversed order walks from the LSB (last typed) upward.
  assign sel   = REVERSE ? idx : LAST - idx;
  assign digit = |(value & (DIGITS'(1) << sel));

  // NOTE: every output of this block gets a default first, so no latches.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    tx_byte   = ASCII_ZERO;
    case (state)
      COLLECT: if (complete) state_nxt = PRINT;
      PRINT: begin
        req     = 1'b1;
        tx_byte = ASCII_ZERO | {7'd0, digit};
        if (done && idx == LAST) state_nxt = APPEND_CRLF ? CR : COLLECT;
      end
      CR: begin
        req     = 1'b1;
        tx_byte = ASCII_CR;
        if (done) state_nxt = LF;
      end
      LF: begin
        req     = 1'b1;
        tx_byte = ASCII_LF;
        if (done) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      idx         <= '0;
      shreg       <= '0;
      value       <= '0;
      value_valid <= 1'b0;
    end else begin
      value_valid <= complete;
      if (complete) begin
        value <= shreg_next;
        shreg <= '0;
        count <= '0;
      end else if (accept_digit) begin
        shreg <= shreg_next;
        count <= count + 1'b1;
      end else if (accept_erase) begin
        shreg <= shreg >> 1;
        count <= count - 1'b1;
      end
      if (complete)                                     idx <= '0;
      else if (state == PRINT && done && idx != LAST)   idx <= idx + 1'b1;
    end
  end

  tx_byte_sequencer u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .tx_byte     (tx_byte),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .done        (done)
  );

endmodule

// File: tb/tb_bit_echo_printer.sv
// Scoreboard bench: three configurations (8/rev/crlf, 8/fwd/plain, 1/rev/crlf)
// driven by directed and random entries against a digit-list reference model.
module tb_bit_echo_printer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  rx_data [3];
  logic        new_rx  [3];
  logic        tx_busy [3];
  logic [7:0]  tx_data [3];
  logic        new_tx  [3];
  logic        vvalid  [3];
  logic        busy    [3];
  logic [7:0]  val0, val1;
  logic [0:0]  val2;
  logic [31:0] val     [3];

  always_comb begin
    val[0] = 32'(val0);
    val[1] = 32'(val1);
    val[2] = 32'(val2);
  end

  bit_echo_printer #(.DIGITS(8), .REVERSE(1'b1), .APPEND_CRLF(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data[0]), .new_rx_data(new_rx[0]),
    .tx_data(tx_data[0]), .new_tx_data(new_tx[0]), .tx_busy(tx_busy[0]),
    .value(val0), .value_valid(vvalid[0]), .busy(busy[0]));
  bit_echo_printer #(.DIGITS(8), .REVERSE(1'b0), .APPEND_CRLF(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data[1]), .new_rx_data(new_rx[1]),
    .tx_data(tx_data[1]), .new_tx_data(new_tx[1]), .tx_busy(tx_busy[1]),
    .value(val1), .value_valid(vvalid[1]), .busy(busy[1]));
  bit_echo_printer #(.DIGITS(1), .REVERSE(1'b1), .APPEND_CRLF(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data[2]), .new_rx_data(new_rx[2]),
    .tx_data(tx_data[2]), .new_tx_data(new_tx[2]), .tx_busy(tx_busy[2]),
    .value(val2), .value_valid(vvalid[2]), .busy(busy[2]));

  // Transmitter model: busy rises one cycle after a strobe, for lat[u] cycles.
  int cnt [3];
  int lat [3];
  bit force_busy [3];

  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (new_tx[u])       cnt[u] <= lat[u];
      else if (cnt[u] > 0) cnt[u] <= cnt[u] - 1;
    end
  end

  always_comb begin
    for (int u = 0; u < 3; u++) tx_busy[u] = force_busy[u] || (cnt[u] > 0);
  end

  // Reference model state and scoreboard queues.
  bit          dig   [3][$];
  logic [7:0]  tx_q  [3][$];
  logic [31:0] val_q [3][$];
  logic [31:0] exp_hold [3];
  int          strobe_cnt [3];
  int          vv_cnt [3];
  logic        prev_new [3];
  logic        prev_busy [3];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic int ndig(input int u);
    return (u == 2) ? 1 : 8;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_rx(input int u, input logic [7:0] b);
    logic [31:0] v;
    int n;
    if (tx_q[u].size() != 0) return;
    if (b == 8'h30 || b == 8'h31) begin
      dig[u].push_back(b[0]);
      n = dig[u].size();
      if (n == ndig(u)) begin
        v = 0;
        for (int i = 0; i < n; i++) v = (v << 1) | 32'(dig[u][i]);
        val_q[u].push_back(v);
        if (u != 1) for (int i = n - 1; i >= 0; i--) tx_q[u].push_back(8'h30 + 8'(dig[u][i]));
        else        for (int i = 0; i < n; i++)      tx_q[u].push_back(8'h30 + 8'(dig[u][i]));
        if (u != 1) begin
          tx_q[u].push_back(8'h0D);
          tx_q[u].push_back(8'h0A);
        end
        dig[u].delete();
      end
    end else if ((b == 8'h08 || b == 8'h7F) && dig[u].size() > 0) begin
      void'(dig[u].pop_back());
    end
  endtask

  // Monitor: pops expectations whenever a DUT presents a strobe or pulse.
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (!rst_n) begin
        prev_new[u]  <= 1'b0;
        prev_busy[u] <= 1'b0;
        exp_hold[u]  <= '0;
      end else begin
        if (new_tx[u]) begin
          strobe_cnt[u]++;
          check($sformatf("u%0d_tx_gap", u), 32'(prev_new[u]), 0);
          check($sformatf("u%0d_tx_busy_respected", u), 32'(prev_busy[u]), 0);
          if (tx_q[u].size() == 0) check($sformatf("u%0d_tx_unexpected", u), 32'(new_tx[u]), 0);
          else check($sformatf("u%0d_tx_data", u), 32'(tx_data[u]), 32'(tx_q[u].pop_front()));
        end
        if (vvalid[u]) begin
          vv_cnt[u]++;
          if (val_q[u].size() == 0) check($sformatf("u%0d_vvalid_unexpected", u), 32'(vvalid[u]), 0);
          else begin
            exp_hold[u] <= val_q[u][0];
            check($sformatf("u%0d_value", u), val[u], val_q[u].pop_front());
          end
        end
        prev_new[u]  <= new_tx[u];
        prev_busy[u] <= tx_busy[u];
      end
    end
  end

  task automatic rx_byte(input int u, input logic [7:0] b);
    rx_data[u] = b;
    new_rx[u]  = 1'b1;
    model_rx(u, b);
    @(posedge clk); #1;
  endtask

  task automatic rx_idle(input int u);
    new_rx[u]  = 1'b0;
    rx_data[u] = 8'h00;
  endtask

  task automatic send_str(input int u, input string s);
    for (int i = 0; i < s.len(); i++) rx_byte(u, s[i]);
    rx_idle(u);
  endtask

  task automatic wait_idle(input int u);
    int n = 0;
    while ((tx_q[u].size() != 0 || val_q[u].size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check($sformatf("u%0d_idle_timeout", u), 32'(n < 3000), 1);
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("u%0d_busy_idle", u), 32'(busy[u]), 0);
    check($sformatf("u%0d_value_hold", u), val[u], exp_hold[u]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base, base_vv, n, u;
    logic [7:0] b;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_data[i] = 8'h00;
      new_rx[i]  = 1'b0;
      lat[i]     = 3;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d_rst_tx_data", i), 32'(tx_data[i]), 0);
      check($sformatf("u%0d_rst_new_tx", i), 32'(new_tx[i]), 0);
      check($sformatf("u%0d_rst_busy", i), 32'(busy[i]), 0);
      check($sformatf("u%0d_rst_value", i), val[i], 0);
      check($sformatf("u%0d_rst_vvalid", i), 32'(vvalid[i]), 0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reverse echo with CR/LF, transmitter busy 3 cycles per byte.
    base_vv = vv_cnt[0];
    base    = strobe_cnt[0];
    send_str(0, "10110010");
    wait_idle(0);
    check("t1_value", val[0], 32'hB2);
    check("t1_vvalid_pulses", 32'(vv_cnt[0] - base_vv), 1);
    check("t1_strobes", 32'(strobe_cnt[0] - base), 10);

    // Forward echo without terminator.
    base = strobe_cnt[1];
    send_str(1, "00000001");
    wait_idle(1);
    check("t2_value", val[1], 32'h01);
    check("t2_strobes", 32'(strobe_cnt[1] - base), 8);

    // Editing: erase at count 0, junk byte, backspace and delete.
    lat[0] = 1;
    rx_byte(0, 8'h08);
    rx_byte(0, "1");
    rx_byte(0, "x");
    rx_byte(0, "1");
    rx_byte(0, 8'h7F);
    send_str(0, "0000001");
    wait_idle(0);
    check("t3_value", val[0], 32'h81);

    // Transmitter held busy through PRINT; an rx digit meanwhile is dropped.
    lat[0] = 2;
    send_str(0, "0101100");
    base = strobe_cnt[0];
    force_busy[0] = 1'b1;
    rx_byte(0, "1");
    rx_idle(0);
    repeat (20) @(posedge clk);
    #1;
    rx_byte(0, "1");
    rx_idle(0);
    repeat (29) @(posedge clk);
    #1;
    check("t4_stall_no_strobe", 32'(strobe_cnt[0] - base), 0);
    check("t4_stall_busy", 32'(busy[0]), 1);
    force_busy[0] = 1'b0;
    wait_idle(0);
    check("t4_value", val[0], 32'h59);
    send_str(0, "00000011");
    wait_idle(0);
    check("t4_next_entry", val[0], 32'h03);

    // Single-digit entries; following back-to-back bytes land in PRINT.
    send_str(2, "1");
    wait_idle(2);
    check("t5_value", val[2], 32'h1);
    send_str(2, "10");
    wait_idle(2);
    rx_byte(2, "0");
    rx_byte(2, 8'h08);
    rx_idle(2);
    wait_idle(2);
    check("t5_edit_after_done", val[2], 32'h0);

    // Random entries with junk, erases, gaps and random transmitter latency.
    for (int e = 0; e < 40; e++) begin
      u = $urandom_range(0, 2);
      lat[u] = $urandom_range(0, 4);
      n = 0;
      while (tx_q[u].size() == 0 && n < 200) begin
        case ($urandom_range(0, 9))
          7:       b = $urandom_range(0, 1) ? 8'h08 : 8'h7F;
          8:       b = 8'($urandom_range(0, 255));
          default: b = 8'h30 + 8'($urandom_range(0, 1));
        endcase
        rx_byte(u, b);
        if ($urandom_range(0, 3) == 0) begin
          rx_idle(u);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
        n++;
      end
      rx_idle(u);
      wait_idle(u);
    end

    // Reset in the middle of printing, after three bytes have gone out.
    lat[0] = 2;
    base = strobe_cnt[0];
    send_str(0, "10101010");
    n = 0;
    while (strobe_cnt[0] < base + 3 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t7_reach_third_byte", 32'(n < 2000), 1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_new_tx", 32'(new_tx[0]), 0);
    check("t7_rst_tx_data", 32'(tx_data[0]), 0);
    check("t7_rst_busy", 32'(busy[0]), 0);
    check("t7_rst_value", val[0], 0);
    check("t7_rst_vvalid", 32'(vvalid[0]), 0);
    for (int i = 0; i < 3; i++) begin
      tx_q[i].delete();
      val_q[i].delete();
      dig[i].delete();
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = strobe_cnt[0];
    send_str(0, "11111111");
    wait_idle(0);
    check("t7_value", val[0], 32'hFF);
    check("t7_full_echo", 32'(strobe_cnt[0] - base), 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
